frame_buffer_reader: RTL

Raster-order read-out engine for the 4-bit indexed frame buffer. Sprite and vector engines write pixels into this memory; this block streams them back out to the display path. It sweeps linear addresses 0..WIDTH*HEIGHT-1 and issues one-cycle-latency memory reads. Returned pixels are buffered in a small credit-controlled FIFO and presented on a valid/ready stream tagged with frame boundaries.

---
 rtl/frame_buffer_pkg.sv | 21 ++
 rtl/frame_buffer_reader_fifo.sv | 46 ++++
 rtl/frame_buffer_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared constants and FIFO entry type for the indexed frame buffer read-out path.
package frame_buffer_pkg;

    localparam int FB_WIDTH         = 640;
    localparam int FB_HEIGHT        = 400;
    localparam int FB_PIXELS        = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDRESS_WIDTH = 18;
    localparam int FB_PIXEL_WIDTH   = 4;

    typedef struct packed {
        logic                      first;
        logic                      last;
        logic [FB_PIXEL_WIDTH-1:0] data;
    } fb_pixel_entry_t;

    typedef enum logic {
        IDLE,
        FETCH
    } fb_reader_state_t;

endpackage

// File: rtl/frame_buffer_reader_fifo.sv
// Purpose: synchronous FIFO with push, pop, flush and occupancy count.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the producer must never push when full.
module frame_buffer_reader_fifo #(
    parameter type entry_t = logic [5:0],
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             flush,
    input  logic             push_vld,
    input  entry_t           push_dat,
    input  logic             pop_vld,
    output entry_t           head_dat,
    output logic [CNT_W-1:0] count
);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    always_ff @(posedge clock_in) begin
        if (reset_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_vld)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_vld && !pop_vld)
                count <= count + CNT_W'(1);
            else if (!push_vld && pop_vld)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock_in) begin
        if (push_vld && !flush)
            mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/frame_buffer_reader.sv
// Purpose: raster scan-out of the 4-bit frame buffer; FRAME_BUFFER_READER_DOUBLE_BUFFER_EN adds bank swap.
// Latency: 3 edges from enable_in to first pixel_valid_out, then 1 pixel/cycle.
// Backpressure: reads are credit-limited so occupancy + in-flight never exceeds FIFO_DEPTH.
module frame_buffer_reader
    import frame_buffer_pkg::*;
#(
    parameter int WIDTH      = FB_WIDTH,
    parameter int HEIGHT     = FB_HEIGHT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock_in,
    input  logic                        reset_in,
    input  logic                        enable_in,
    output logic                        pixel_read_enable_out,
    output logic [FB_ADDRESS_WIDTH-1:0] pixel_read_address_out,
    input  logic [FB_PIXEL_WIDTH-1:0]   pixel_read_data_in,
    output logic [FB_PIXEL_WIDTH-1:0]   pixel_data_out,
    output logic                        pixel_valid_out,
    input  logic                        pixel_ready_in,
    output logic                        first_pixel_out,
    output logic                        last_pixel_out
`ifdef FRAME_BUFFER_READER_DOUBLE_BUFFER_EN
    ,
    input  logic                        buffer_swap_request_in,
    output logic                        buffer_bank_out,
    output logic                        buffer_swap_done_out
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [FB_ADDRESS_WIDTH-1:0] LAST_ADDR = FB_ADDRESS_WIDTH'(WIDTH * HEIGHT - 1);

    fb_reader_state_t              state;
    logic [FB_ADDRESS_WIDTH-1:0]   addr_cnt;
    logic [CNT_W-1:0]              fifo_count;
    fb_pixel_entry_t               push_dat;
    fb_pixel_entry_t               head_dat;
    logic                          credit_ok;
    logic                          issue;
    logic                          pop_vld;

    // Occupancy is taken before this cycle's pop, so a credit freed by a pop is reused one cycle later.
    assign credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, pixel_read_enable_out})
                       < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue     = (state == FETCH) && enable_in && credit_ok;

    always_ff @(posedge clock_in) begin
        if (reset_in || !enable_in) begin
            state                  <= IDLE;
            addr_cnt               <= '0;
            pixel_read_enable_out  <= 1'b0;
            pixel_read_address_out <= '0;
        end else begin
            state                 <= FETCH;
            pixel_read_enable_out <= issue;
            if (issue) begin
                pixel_read_address_out <= addr_cnt;
                addr_cnt <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + FB_ADDRESS_WIDTH'(1);
            end
        end
    end

    always_comb begin
        push_dat       = '0;
        push_dat.first = (pixel_read_address_out == '0);
        push_dat.last  = (pixel_read_address_out == LAST_ADDR);
        push_dat.data  = pixel_read_data_in;
    end

    assign pop_vld = pixel_valid_out && pixel_ready_in;

    frame_buffer_reader_fifo #(
        .entry_t (fb_pixel_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .flush    (!enable_in),
        .push_vld (pixel_read_enable_out),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // FIFO storage is not reset, so head fields are masked until an entry exists.
    assign pixel_valid_out = (fifo_count != '0);
    assign pixel_data_out  = pixel_valid_out ? head_dat.data : '0;
    assign first_pixel_out = pixel_valid_out && head_dat.first;
    assign last_pixel_out  = pixel_valid_out && head_dat.last;

`ifdef FRAME_BUFFER_READER_DOUBLE_BUFFER_EN
    logic swap_pend;
    logic swap_arm;
    logic last_issue;

    assign last_issue = issue && (addr_cnt == LAST_ADDR);

    // The swap is armed by the last-address read and lands with the following address-0 read.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            swap_pend            <= 1'b0;
            swap_arm             <= 1'b0;
            buffer_bank_out      <= 1'b0;
            buffer_swap_done_out <= 1'b0;
        end else if (!enable_in) begin
            swap_pend            <= 1'b0;
            swap_arm             <= 1'b0;
            buffer_swap_done_out <= 1'b0;
        end else begin
            buffer_swap_done_out <= issue && swap_arm;
            if (issue && swap_arm) begin
                buffer_bank_out <= ~buffer_bank_out;
                swap_arm        <= 1'b0;
            end
            if (last_issue && swap_pend) begin
                swap_arm  <= 1'b1;
                swap_pend <= buffer_swap_request_in;
            end else if (buffer_swap_request_in) begin
                swap_pend <= 1'b1;
            end
        end
    end
`endif

endmodule
